// File: rtl/fu_shift_pkg.sv
// ============================================================================
// Module      : fu_shift_pkg
// Description : Shared opcodes, FSM state encoding and widths for the shift
//               sequencer of the Mosaic functional unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fu_shift_pkg;

  localparam int DATA_W  = 32;
  localparam int SHIFT_W = 5;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PASS_A = 3'd1,
    PASS_B = 3'd2,
    FINAL  = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage : fu_shift_pkg

`default_nettype wire

// File: rtl/shift_pass_decode.sv
// ============================================================================
// Module      : shift_pass_decode
// Description : Maps an opcode/amount/pass index onto barrel-shifter controls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_pass_decode
  import fu_shift_pkg::*;
(
  input  logic [1:0]         i_op_code,
  input  logic [SHIFT_W-1:0] i_op_amt,
  input  logic               i_second_pass,
  output logic [SHIFT_W-1:0] o_sh_s,
  output logic               o_sh_left,
  output logic               o_sh_log
);

  always_comb begin
    o_sh_s    = i_op_amt;
    o_sh_left = 1'b0;
    o_sh_log  = 1'b1;
    case (i_op_code)
      OP_SLL: o_sh_left = 1'b1;
      OP_SRA: o_sh_log  = 1'b0;
      OP_ROR: begin
        // Second rotate pass is a left shift by (32 - amt) mod 32.
        if (i_second_pass) begin
          o_sh_s    = SHIFT_W'(~i_op_amt + 1'b1);
          o_sh_left = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule : shift_pass_decode

`default_nettype wire

// File: rtl/shift_seq.sv
// ============================================================================
// Module      : shift_seq
// Description : Valid/ready sequencer driving an external barrel shifter;
//               rotate-right is built from an SRL pass ORed with an SLL pass.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_seq
  import fu_shift_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [DATA_W-1:0]  IN_DATA,
  input  logic [SHIFT_W-1:0] IN_AMT,
  input  logic [1:0]         IN_OP,
  input  logic [TAG_W-1:0]   IN_TAG,
  output logic [DATA_W-1:0]  SH_X,
  output logic [SHIFT_W-1:0] SH_S,
  output logic               SH_LEFT,
  output logic               SH_LOG,
  input  logic [DATA_W-1:0]  SH_Z,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [DATA_W-1:0]  OUT_DATA,
  output logic [TAG_W-1:0]   OUT_TAG
);

  state_e             r_state;
  state_e             w_next_state;
  logic [DATA_W-1:0]  r_op_data;
  logic [SHIFT_W-1:0] r_op_amt;
  logic [1:0]         r_op_code;
  logic [TAG_W-1:0]   r_op_tag;
  logic [DATA_W-1:0]  r_partial;
  logic [DATA_W-1:0]  r_result;

  logic               w_drive;
  logic               w_second;
  logic               w_is_ror;
  logic [SHIFT_W-1:0] w_dec_s;
  logic               w_dec_left;
  logic               w_dec_log;

  assign w_is_ror = (r_op_code == OP_ROR);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    IN_READY     = 1'b0;
    OUT_VALID    = 1'b0;
    w_drive      = 1'b0;
    w_second     = 1'b0;
    case (r_state)
      IDLE: begin
        IN_READY = 1'b1;
        if (IN_VALID) w_next_state = PASS_A;
      end
      PASS_A: begin
        w_drive      = 1'b1;
        w_next_state = PASS_B;
      end
      PASS_B: begin
        if (w_is_ror) begin
          w_drive      = 1'b1;
          w_second     = 1'b1;
          w_next_state = FINAL;
        end else begin
          w_next_state = DONE;
        end
      end
      FINAL:   w_next_state = DONE;
      DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_op_data <= '0;
      r_op_amt  <= '0;
      r_op_code <= '0;
      r_op_tag  <= '0;
      r_partial <= '0;
      r_result  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (IN_VALID) begin
            r_op_data <= IN_DATA;
            r_op_amt  <= IN_AMT;
            r_op_code <= IN_OP;
            r_op_tag  <= IN_TAG;
          end
        end
        PASS_B: begin
          if (w_is_ror) r_partial <= SH_Z;
          else          r_result  <= SH_Z;
        end
        FINAL:   r_result <= r_partial | SH_Z;
        default: ;
      endcase
    end
  end

  shift_pass_decode u_decode (
    .i_op_code    (r_op_code),
    .i_op_amt     (r_op_amt),
    .i_second_pass(w_second),
    .o_sh_s       (w_dec_s),
    .o_sh_left    (w_dec_left),
    .o_sh_log     (w_dec_log)
  );

  // Outside an active pass the shifter sees a neutral logical right shift by 0.
  assign SH_X     = r_op_data;
  assign SH_S     = w_drive ? w_dec_s    : '0;
  assign SH_LEFT  = w_drive ? w_dec_left : 1'b0;
  assign SH_LOG   = w_drive ? w_dec_log  : 1'b1;
  assign OUT_DATA = r_result;
  assign OUT_TAG  = r_op_tag;

endmodule : shift_seq

`default_nettype wire

// File: doc/shift_seq.md
# shift_seq

Operation sequencer upstream of the bi-directional barrel shifter in the Mosaic functional unit. Accepts shift/rotate requests over a valid/ready handshake and drives the shifter's X/S/LEFT/LOG inputs. It collects the shifter's Z output one cycle later and presents the result downstream over a second valid/ready handshake. Rotate-right needs two shifter passes, SRL then SLL, ORed together. The block sequences these passes with an FSM.

## Interface
- `TAG_W`, default 4: width of request tag carried through to result.
- `CLOCK` in 1: sole clock, rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `IN_VALID` in 1: request valid.
- `IN_READY` out 1: request accepted when `IN_VALID & IN_READY` at a rising edge.
- `IN_DATA` in 32: operand.
- `IN_AMT` in 5: shift/rotate amount, 0–31.
- `IN_OP` in 2: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- `IN_TAG` in TAG_W: opaque tag.
- `SH_X` out 32: to shifter X.
- `SH_S` out 5: to shifter S.
- `SH_LEFT` out 1: to shifter LEFT.
- `SH_LOG` out 1: to shifter LOG.
- `SH_Z` in 32: from shifter Z; valid the cycle after SH_* are presented.
- `OUT_VALID` out 1: result valid.
- `OUT_READY` in 1: downstream accepts when `OUT_VALID & OUT_READY` at a rising edge.
- `OUT_DATA` out 32: result.
- `OUT_TAG` out TAG_W: tag of the result.

## Operation
- Registers: `op_data`, `op_amt`, `op_code`, `op_tag`, `partial`(32), `result`(32), `state`.
- States:
  - `IDLE`: `IN_READY`=1. On accept, capture the IN_* fields and go to `PASS_A`.
  - `PASS_A`: drive the first pass and go to `PASS_B`.
  - `PASS_B`: `SH_Z` holds the first-pass result.
    - Non-ROR: `result<=SH_Z`, go to `DONE`.
    - ROR: `partial<=SH_Z`, drive the second pass, go to `FINAL`.
  - `FINAL`: `result<=partial|SH_Z`, go to `DONE`.
  - `DONE`: `OUT_VALID`=1. On `OUT_READY`, go to `IDLE`.
- `SH_X`=`op_data` at all times.
- Pass decode:
  - SLL: S=amt, LEFT=1, LOG=1.
  - SRL: S=amt, LEFT=0, LOG=1.
  - SRA: S=amt, LEFT=0, LOG=0.
  - ROR pass 1: SRL by amt.
  - ROR pass 2: SLL by `(32-amt) mod 32`, a 5-bit two's-complement negate with the carry dropped.
- In states other than `PASS_A` and `PASS_B`-with-ROR: SH_S=0, SH_LEFT=0, SH_LOG=1.
- Amount 0:
  - Every op returns `op_data` unchanged.
  - ROR 0 computes X|X=X. No special case is needed in this block, because the shifter returns X on a left shift by 0.
- `OUT_DATA`=`result`, `OUT_TAG`=`op_tag`. Both are stable while `OUT_VALID`=1 and `OUT_READY`=0.
- One operation in flight. `IN_READY`=0 in every state except `IDLE`. No overlap with `DONE`.
- Reset values: state=`IDLE`, `IN_READY`=1, `OUT_VALID`=0, `OUT_DATA`=0, `OUT_TAG`=0, `SH_X`=0, `SH_S`=0, `SH_LEFT`=0, `SH_LOG`=1, `partial`=0.

## Timing
- Accept at edge k. `PASS_A` occupies cycle k+1 and `PASS_B` occupies k+2.
- Non-ROR: `OUT_VALID` high from cycle k+3.
- ROR: `FINAL` occupies k+3; `OUT_VALID` high from k+4.
- Handshake at edge m (`DONE`, `OUT_READY`=1):
  - `IDLE` and `IN_READY`=1 from cycle m+1.
  - Best-case throughput is 1 op per 4 cycles, or 1 per 5 for ROR.
- `OUT_READY` held low: stay in `DONE` indefinitely with outputs frozen.
- `IN_VALID` while not `IDLE` is ignored. The request is not consumed, and the upstream stage holds it.
- `RESET` asserted in any state, mid-pass included: all registers take reset values immediately, without waiting for a clock edge. The in-flight op is discarded with no output.
- `SH_Z` is sampled only in `PASS_B` and `FINAL`. It is ignored in all other states.

## Structure
- Shared package `fu_shift_pkg`: opcode constants (`OP_SLL`, `OP_SRL`, `OP_SRA`, `OP_ROR`), state encoding (`IDLE`, `PASS_A`, `PASS_B`, `FINAL`, `DONE`), `SHIFT_W`=5, `DATA_W`=32.
- Natural sub-module `shift_pass_decode`: combinational, takes (op_code, op_amt, second_pass) and returns (S, LEFT, LOG). Keeps the FSM file free of decode logic.
- The shifter is instantiated beside this block in the functional-unit top, not inside it.

## Test plan
- SLL, X=0x00000001, amt=4, tag=3 → OUT_DATA=0x00000010, OUT_TAG=3, `OUT_VALID` exactly 3 cycles after the accept edge.
- X=0x80000000, amt=31:
  - SRA → 0xFFFFFFFF.
  - SRL → 0x00000001.
  - SLL by 0 → 0x80000000.
- ROR, X=0x12345678:
  - amt=8 → 0x78123456, `OUT_VALID` 4 cycles after accept.
  - amt=0 → 0x12345678.
  - amt=31 → 0x2468ACF0.
- Backpressure: SLL result held with `OUT_READY`=0 for 5 cycles, `IN_VALID`=1 throughout → OUT_DATA/OUT_TAG stable, `IN_READY`=0. Raise `OUT_READY` → `IN_READY`=1 the next cycle, then the pending request is accepted.
- `RESET` pulsed mid-cycle during `FINAL` of a ROR → `OUT_VALID`=0 and `IN_READY`=1 without a clock edge. No result for that tag ever appears, and the next request completes normally.
- Back-to-back random ops with `OUT_READY`=1 → each result matches the reference model, and the SH_* decode matches the table on every `PASS_A`/`PASS_B` cycle.
